// File: rtl/zero_run_serializer_if.sv
// zero_run_serializer_if: word handshake plus serial-side outputs of the serializer
// Ports: load/data in, ready out (combinational), out/active/last serial line, zero_count run tally
interface zero_run_serializer_if #(parameter int WIDTH = 8);
  logic load;
  logic [WIDTH-1:0] data;
  logic ready;
  logic out;
  logic active;
  logic last;
  logic [2:0] zero_count;
  modport master (output load, data, input ready, out, active, last, zero_count);
  modport slave (input load, data, output ready, out, active, last, zero_count);
endinterface

// File: rtl/zero_run_serializer.sv
// zero_run_serializer: MSB-first word serializer that counts emitted zero runs of length >= 3
// Ports: clk, reset (sync active-low), bus.slave (load/data/ready handshake, out/active/last, zero_count)
module zero_run_serializer #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic reset,
  zero_run_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic [1:0] run;
  logic out_r, active_r, last_r;
  logic [2:0] zc;
  logic accept;
  assign bus.ready = (state == IDLE) | (state == SHIFT & last_r);
  assign accept = bus.load & bus.ready;
  assign bus.out = out_r;
  assign bus.active = active_r;
  assign bus.last = last_r;
  assign bus.zero_count = zc;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      run <= '0;
      out_r <= 1'b1;
      active_r <= 1'b0;
      last_r <= 1'b0;
      zc <= '0;
    end else begin
      // tracker sees the bit currently on the line; 2->3 marks a new run
      run <= (active_r & ~out_r) ? ((run == 2'd3) ? 2'd3 : run + 2'd1) : 2'd0;
      if (active_r & ~out_r & run == 2'd2) zc <= zc + 3'd1;
      if (accept) begin
        state <= SHIFT;
        sreg <= bus.data;
        cnt <= '0;
        out_r <= bus.data[WIDTH-1];
        active_r <= 1'b1;
        last_r <= 1'b0;
      end else if (state == SHIFT) begin
        if (!last_r) begin
          sreg <= sreg << 1;
          cnt <= cnt + 1'b1;
          out_r <= sreg[WIDTH-2];
          last_r <= cnt == CW'(WIDTH-2);
        end else begin
          state <= IDLE;
          out_r <= 1'b1;
          active_r <= 1'b0;
          last_r <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_zero_run_serializer.sv
// tb_zero_run_serializer: scoreboard bench for zero_run_serializer
module tb_zero_run_serializer;
  typedef struct {logic b; logic l;} exp_t;
  logic clk = 0;
  logic reset = 1;
  logic mon_en = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  zero_run_serializer_if #(.WIDTH(8)) bus();
  zero_run_serializer #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (bus.active === 1'b1) begin
      if (q.size() == 0) chk("unexpected_bit", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("bit", bus.out, e.b);
        chk("last", bus.last, e.l);
      end
    end else begin
      chk("idle_out", bus.out, 1);
      chk("idle_last", bus.last, 0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask
  task automatic send(input logic [7:0] d, input int n);
    bus.load = 1;
    bus.data = d;
    @(posedge clk);
    #1;
    bus.load = 0;
    for (int i = 0; i < n; i++) q.push_back('{d[7-i], i == 7});
  endtask
  initial begin
    bus.load = 0;
    bus.data = '0;
    do_reset();
    mon_en = 1;
    chk("rst_out", bus.out, 1);
    chk("rst_ready", bus.ready, 1);
    chk("rst_active", bus.active, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_zc", bus.zero_count, 0);
    send(8'b1000_1111, 8);
    repeat (3) tick();
    chk("single_zc_k4", bus.zero_count, 0);
    tick();
    chk("single_zc_k5", bus.zero_count, 1);
    repeat (4) tick();
    chk("single_done_active", bus.active, 0);
    chk("single_done_ready", bus.ready, 1);
    do_reset();
    tick();
    send(8'h00, 8);
    repeat (8) tick();
    chk("long_zc", bus.zero_count, 1);
    repeat (3) tick();
    chk("long_zc_hold", bus.zero_count, 1);
    do_reset();
    send(8'hF0, 8);
    repeat (7) tick();
    chk("b2b_ready_last", bus.ready, 1);
    send(8'h0F, 8);
    chk("b2b_no_gap", bus.active, 1);
    repeat (8) tick();
    chk("b2b_zc", bus.zero_count, 1);
    do_reset();
    send(8'hF0, 8);
    repeat (8) tick();
    send(8'h0F, 8);
    repeat (8) tick();
    chk("gap_zc", bus.zero_count, 2);
    do_reset();
    for (int w = 0; w < 9; w++) begin
      send(8'h00, 8);
      repeat (8) tick();
      chk("wrap_zc", bus.zero_count, (w + 1) % 8);
    end
    do_reset();
    send(8'hFF, 8);
    repeat (3) tick();
    chk("ign_ready", bus.ready, 0);
    bus.load = 1;
    bus.data = 8'hAA;
    tick();
    bus.load = 0;
    repeat (4) tick();
    chk("ign_idle", bus.active, 0);
    tick();
    chk("ign_not_sent", bus.active, 0);
    send(8'h00, 5);
    repeat (4) tick();
    chk("mid_zc_before", bus.zero_count, 1);
    reset = 0;
    tick();
    reset = 1;
    chk("mid_out", bus.out, 1);
    chk("mid_active", bus.active, 0);
    chk("mid_zc", bus.zero_count, 0);
    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
